ps2_key_streamer: RTL and testbench

- Parametrised PS/2 device-side keyboard emulator; successor to the single-byte PS2_keyboard model driven by key_action/scan_code.
- Accepts key events, not single bytes, through a valid/ready interface into a FIFO.
- Expands each event into make, extended (E0) and break (F0) byte sequences, then serialises them as 11-bit PS/2 frames on ps2_clk/ps2_dat.
- Sits in the simulation bench between the DESim key-event source and the DUT's PS2_CLK/PS2_DAT inputs; also synthesisable for loopback on board.

---
 rtl/ps2_key_streamer.sv | 227 ++++++++++++++++++++++
 tb/tb_ps2_key_streamer.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_streamer.sv
// PS/2 device-side keyboard emulator: key events -> FIFO -> E0/F0/code byte frames.
// Define PS2_TYPEMATIC_EN to enable typematic repeat of the last held make key.
module ps2_key_streamer #(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned CLK_HALF   = 1250,
    parameter int unsigned GAP_CYCLES = 2500
`ifdef PS2_TYPEMATIC_EN
    ,
    parameter int unsigned TM_DELAY   = 25000000,
    parameter int unsigned TM_PERIOD  = 5000000
`endif
) (
    input  logic                   CLOCK_50,
    input  logic                   resetn,
    input  logic                   ev_valid,
    output logic                   ev_ready,
    input  logic [7:0]             ev_code,
    input  logic                   ev_ext,
    input  logic                   ev_break,
    output logic                   ps2_clk,
    output logic                   ps2_dat,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count
);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [2:0] {StIdle, StLoad, StPreE0, StPreF0, StCode} state_e;

    state_e        state_q;
    logic          gap_q;
    logic [3:0]    bit_q;
    logic [31:0]   cnt_q;
    logic [10:0]   sh_q;
    logic          cur_brk_q;
    logic [7:0]    cur_code_q;
    logic          ps2_clk_q;
    logic          ps2_dat_q;

    logic [9:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [AW:0]   count_q;
    logic          push;
    logic          pop;
    logic [9:0]    fifo_rd;

    logic          gap_done;
    logic          launch;
    state_e        launch_state;
    logic [7:0]    launch_byte;

`ifdef PS2_TYPEMATIC_EN
    logic          cur_ext_q;
    logic          cur_rep_q;
    logic          held_q;
    logic          held_ext_q;
    logic [7:0]    held_code_q;
    logic [31:0]   tm_cnt_q;
    logic          tm_rep_q;
    logic [31:0]   tm_limit;

    assign tm_limit = tm_rep_q ? 32'(TM_PERIOD - 1) : 32'(TM_DELAY - 1);
`endif

    function automatic logic [10:0] frame_of(input logic [7:0] d);
        return {1'b1, ~^d, d, 1'b0};
    endfunction

    assign ev_ready   = (count_q != (AW+1)'(DEPTH));
    assign push       = ev_valid & ev_ready;
    assign pop        = (state_q == StLoad);
    assign fifo_rd    = mem_q[rptr_q];
    assign fifo_count = count_q;
    assign busy       = (state_q != StIdle) | (count_q != '0);
    assign ps2_clk    = ps2_clk_q;
    assign ps2_dat    = ps2_dat_q;

    always_ff @(posedge CLOCK_50) begin
        if (push) mem_q[wptr_q] <= {ev_ext, ev_break, ev_code};
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + AW'(1);
            if (pop)  rptr_q <= rptr_q + AW'(1);
            count_q <= count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    // Decides when a new byte frame starts and which byte/state it belongs to.
    always_comb begin
        gap_done     = gap_q && (cnt_q == 32'(GAP_CYCLES - 1));
        launch       = 1'b0;
        launch_state = StCode;
        launch_byte  = cur_code_q;
        case (state_q)
            StIdle: begin
`ifdef PS2_TYPEMATIC_EN
                if (count_q == '0 && held_q && tm_cnt_q >= tm_limit) begin
                    launch       = 1'b1;
                    launch_state = held_ext_q ? StPreE0 : StCode;
                    launch_byte  = held_ext_q ? 8'hE0 : held_code_q;
                end
`endif
            end
            StLoad: begin
                launch = 1'b1;
                if (fifo_rd[9]) begin
                    launch_state = StPreE0;
                    launch_byte  = 8'hE0;
                end else if (fifo_rd[8]) begin
                    launch_state = StPreF0;
                    launch_byte  = 8'hF0;
                end else begin
                    launch_state = StCode;
                    launch_byte  = fifo_rd[7:0];
                end
            end
            StPreE0: begin
                if (gap_done) begin
                    launch       = 1'b1;
                    launch_state = cur_brk_q ? StPreF0 : StCode;
                    launch_byte  = cur_brk_q ? 8'hF0 : cur_code_q;
                end
            end
            StPreF0: begin
                if (gap_done) launch = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q    <= StIdle;
            gap_q      <= 1'b0;
            bit_q      <= '0;
            cnt_q      <= '0;
            sh_q       <= '1;
            cur_brk_q  <= 1'b0;
            cur_code_q <= '0;
            ps2_clk_q  <= 1'b1;
            ps2_dat_q  <= 1'b1;
`ifdef PS2_TYPEMATIC_EN
            cur_ext_q   <= 1'b0;
            cur_rep_q   <= 1'b0;
            held_q      <= 1'b0;
            held_ext_q  <= 1'b0;
            held_code_q <= '0;
            tm_cnt_q    <= '0;
            tm_rep_q    <= 1'b0;
`endif
        end else begin
`ifdef PS2_TYPEMATIC_EN
            if (held_q) tm_cnt_q <= tm_cnt_q + 32'd1;
            if (state_q == StIdle && launch) begin
                cur_ext_q  <= held_ext_q;
                cur_brk_q  <= 1'b0;
                cur_code_q <= held_code_q;
                cur_rep_q  <= 1'b1;
            end
`endif
            if (state_q == StLoad) begin
                cur_brk_q  <= fifo_rd[8];
                cur_code_q <= fifo_rd[7:0];
`ifdef PS2_TYPEMATIC_EN
                cur_ext_q  <= fifo_rd[9];
                cur_rep_q  <= 1'b0;
                held_q     <= 1'b0;
`endif
            end
            if (launch) begin
                state_q   <= launch_state;
                sh_q      <= frame_of(launch_byte);
                ps2_clk_q <= 1'b1;
                ps2_dat_q <= 1'b0;
                cnt_q     <= '0;
                bit_q     <= '0;
                gap_q     <= 1'b0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (count_q != '0) state_q <= StLoad;
                    end
                    StPreE0, StPreF0, StCode: begin
                        if (!gap_q) begin
                            if (cnt_q == 32'(2 * CLK_HALF - 1)) begin
                                cnt_q     <= '0;
                                ps2_clk_q <= 1'b1;
                                if (bit_q == 4'd10) begin
                                    gap_q     <= 1'b1;
                                    ps2_dat_q <= 1'b1;
`ifdef PS2_TYPEMATIC_EN
                                    if (state_q == StCode && !cur_brk_q) begin
                                        held_q      <= 1'b1;
                                        held_ext_q  <= cur_ext_q;
                                        held_code_q <= cur_code_q;
                                        tm_cnt_q    <= '0;
                                        tm_rep_q    <= cur_rep_q;
                                    end
`endif
                                end else begin
                                    bit_q     <= bit_q + 4'd1;
                                    ps2_dat_q <= sh_q[1];
                                    sh_q      <= {1'b1, sh_q[10:1]};
                                end
                            end else begin
                                cnt_q <= cnt_q + 32'd1;
                                if (cnt_q == 32'(CLK_HALF - 1)) ps2_clk_q <= 1'b0;
                            end
                        end else if (gap_done) begin
                            state_q <= (count_q != '0) ? StLoad : StIdle;
                            gap_q   <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + 32'd1;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ps2_key_streamer.sv
// Bench for ps2_key_streamer: a PS/2 receiver decodes frames, compared against expanded events.
module tb_ps2_key_streamer;
    localparam int DEPTH    = 4;
    localparam int CLK_HALF = 4;
    localparam int GAP      = 8;
    localparam int FRAME    = 22 * CLK_HALF;

    logic       CLOCK_50;
    logic       resetn;
    logic       ev_valid;
    logic       ev_ready;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_break;
    logic       ps2_clk;
    logic       ps2_dat;
    logic       busy;
    logic [2:0] fifo_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    ps2_key_streamer #(
        .DEPTH(DEPTH),
        .CLK_HALF(CLK_HALF),
        .GAP_CYCLES(GAP)
`ifdef PS2_TYPEMATIC_EN
        ,
        .TM_DELAY(200),
        .TM_PERIOD(100)
`endif
    ) dut (
        .CLOCK_50(CLOCK_50),
        .resetn(resetn),
        .ev_valid(ev_valid),
        .ev_ready(ev_ready),
        .ev_code(ev_code),
        .ev_ext(ev_ext),
        .ev_break(ev_break),
        .ps2_clk(ps2_clk),
        .ps2_dat(ps2_dat),
        .busy(busy),
        .fifo_count(fifo_count)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    typedef struct {
        logic [10:0] bits;
        int          start_c;
        int          fall0_c;
        int          end_c;
    } frame_t;

    frame_t     rx_q[$];
    logic [7:0] exp_q[$];
    frame_t     cur;
    int         mon_nb = 0;
    logic       armed = 1'b0;
    logic       prev_clk = 1'b1;
    logic       prev_dat = 1'b1;

    // Host-side receiver: samples data on each ps2_clk falling edge.
    always @(negedge CLOCK_50) begin
        if (!resetn) begin
            mon_nb = 0;
            armed  = 1'b0;
        end else begin
            if (mon_nb == 0 && !armed && prev_dat && !ps2_dat && ps2_clk) begin
                armed       = 1'b1;
                cur.start_c = cyc;
                cur.bits    = '0;
            end
            if (armed && prev_clk && !ps2_clk && mon_nb < 11) begin
                cur.bits[mon_nb] = ps2_dat;
                if (mon_nb == 0) cur.fall0_c = cyc;
                mon_nb++;
            end
            if (!prev_clk && ps2_clk && mon_nb == 11) begin
                cur.end_c = cyc;
                rx_q.push_back(cur);
                mon_nb = 0;
                armed  = 1'b0;
            end
        end
        prev_clk = ps2_clk;
        prev_dat = ps2_dat;
    end

    function automatic logic [10:0] model_frame(input logic [7:0] d);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, d, 1'b0};
    endfunction

    function automatic void push_event(input logic [7:0] c, input logic e, input logic b);
        if (e) exp_q.push_back(8'hE0);
        if (b) exp_q.push_back(8'hF0);
        exp_q.push_back(c);
    endfunction

    task automatic do_reset();
        @(negedge CLOCK_50);
        ev_valid = 1'b0;
        resetn   = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        resetn = 1'b1;
        rx_q.delete();
        exp_q.delete();
        repeat (2) @(negedge CLOCK_50);
    endtask

    // Called at a negedge; returns at the negedge after the handshake cycle.
    task automatic send_event(input logic [7:0] c, input logic e, input logic b, output int hs);
        int guard = 0;
        ev_code  = c;
        ev_ext   = e;
        ev_break = b;
        ev_valid = 1'b1;
        while (!ev_ready && guard < 5000) begin
            @(negedge CLOCK_50);
            guard++;
        end
        hs = ev_ready ? cyc : -1;
        @(negedge CLOCK_50);
        ev_valid = 1'b0;
    endtask

    task automatic wait_frames(input int n, input int budget);
        for (int i = 0; i < budget && rx_q.size() < n; i++) @(negedge CLOCK_50);
    endtask

    task automatic test_reset();
        ev_valid = 1'b0;
        resetn   = 1'b0;
        repeat (2) @(negedge CLOCK_50);
        checks++; if (ps2_clk !== 1'b1) begin errors++; $display("FAIL reset_clk: got %b want 1", ps2_clk); end
        checks++; if (ps2_dat !== 1'b1) begin errors++; $display("FAIL reset_dat: got %b want 1", ps2_dat); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
        checks++; if (ev_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ev_ready); end
        resetn = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        checks++; if (busy !== 1'b0 || ps2_dat !== 1'b1) begin
            errors++; $display("FAIL post_reset_idle: busy %b dat %b want 0 1", busy, ps2_dat);
        end
    endtask

    task automatic test_single();
        int hs;
        frame_t f;
        do_reset();
        send_event(8'h1C, 1'b0, 1'b0, hs);
        checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL single_count: got %0d want 1", fifo_count); end
        wait_frames(1, 400);
        checks++; if (rx_q.size() != 1) begin errors++; $display("FAIL single_frames: got %0d want 1", rx_q.size()); end
        if (rx_q.size() >= 1) begin
            f = rx_q[0];
            checks++; if (f.bits !== model_frame(8'h1C)) begin errors++; $display("FAIL single_bits: got %b want %b", f.bits, model_frame(8'h1C)); end
            checks++; if (f.start_c != hs + 3) begin errors++; $display("FAIL single_latency: got %0d want %0d", f.start_c - hs, 3); end
            checks++; if (f.fall0_c != f.start_c + CLK_HALF) begin errors++; $display("FAIL single_high_phase: got %0d want %0d", f.fall0_c - f.start_c, CLK_HALF); end
            checks++; if (f.end_c - f.start_c != FRAME) begin errors++; $display("FAIL single_frame_len: got %0d want %0d", f.end_c - f.start_c, FRAME); end
            while (cyc < f.end_c + GAP - 1) @(negedge CLOCK_50);
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_gap: got %b want 1", busy); end
            @(negedge CLOCK_50);
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b want 0", busy); end
        end
    endtask

    task automatic test_ext_break();
        int hs;
        int lows = 0;
        do_reset();
        push_event(8'h75, 1'b1, 1'b1);
        send_event(8'h75, 1'b1, 1'b1, hs);
        for (int i = 0; i < 800; i++) begin
            if (rx_q.size() == 3 && cyc >= rx_q[2].end_c + GAP - 1) break;
            @(negedge CLOCK_50);
            if (!busy) lows++;
        end
        checks++; if (rx_q.size() != 3) begin errors++; $display("FAIL eb_frames: got %0d want 3", rx_q.size()); end
        if (rx_q.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                checks++; if (rx_q[i].bits !== model_frame(exp_q[i])) begin
                    errors++; $display("FAIL eb_byte%0d: got %b want %b", i, rx_q[i].bits, model_frame(exp_q[i]));
                end
            end
            for (int i = 1; i < 3; i++) begin
                checks++; if (rx_q[i].start_c - rx_q[i-1].end_c != GAP) begin
                    errors++; $display("FAIL eb_gap%0d: got %0d want %0d", i, rx_q[i].start_c - rx_q[i-1].end_c, GAP);
                end
            end
            checks++; if (lows != 0) begin errors++; $display("FAIL eb_busy_high: got %0d low cycles want 0", lows); end
            @(negedge CLOCK_50);
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL eb_busy_end: got %b want 0", busy); end
        end
    endtask

    task automatic test_parity();
        int hs;
        do_reset();
        send_event(8'h00, 1'b0, 1'b0, hs);
        send_event(8'hFF, 1'b0, 1'b0, hs);
        wait_frames(2, 600);
        checks++; if (rx_q.size() != 2) begin errors++; $display("FAIL par_frames: got %0d want 2", rx_q.size()); end
        if (rx_q.size() == 2) begin
            checks++; if (rx_q[0].bits[9] !== 1'b1) begin errors++; $display("FAIL par_00: got %b want 1", rx_q[0].bits[9]); end
            checks++; if (rx_q[1].bits[9] !== 1'b1) begin errors++; $display("FAIL par_ff: got %b want 1", rx_q[1].bits[9]); end
            checks++; if (rx_q[0].bits !== model_frame(8'h00) || rx_q[1].bits !== model_frame(8'hFF)) begin
                errors++; $display("FAIL par_bits: got %b %b want %b %b", rx_q[0].bits, rx_q[1].bits,
                                   model_frame(8'h00), model_frame(8'hFF));
            end
        end
    endtask

    task automatic test_back_to_back();
        int hs;
        int guard;
        bit first;
        bit saw_full = 0;
        logic [7:0] c;
        logic e, b;
        do_reset();
        c = 8'($urandom_range(0, 255)); e = 1'($urandom_range(0, 1)); b = 1'($urandom_range(0, 1));
        push_event(c, e, b);
        send_event(c, e, b, hs);
        repeat (10) @(negedge CLOCK_50);
        ev_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            c = 8'($urandom_range(0, 255)); e = 1'($urandom_range(0, 1)); b = 1'($urandom_range(0, 1));
            ev_code = c; ev_ext = e; ev_break = b;
            guard = 0;
            first = 1;
            while (!ev_ready && guard < 3000) begin
                if (first) begin
                    saw_full = 1;
                    first = 0;
                    checks++; if (fifo_count !== 3'(DEPTH)) begin
                        errors++; $display("FAIL b2b_full_count: got %0d want %0d", fifo_count, DEPTH);
                    end
                end
                @(negedge CLOCK_50);
                guard++;
            end
            push_event(c, e, b);
            @(negedge CLOCK_50);
        end
        ev_valid = 1'b0;
        wait_frames(exp_q.size(), 5000);
        checks++; if (!saw_full) begin errors++; $display("FAIL b2b_ready_drop: got 0 want 1"); end
        checks++; if (rx_q.size() < exp_q.size()) begin errors++; $display("FAIL b2b_frames: got %0d want %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            checks++; if (rx_q[i].bits !== model_frame(exp_q[i])) begin
                errors++; $display("FAIL b2b_byte%0d: got %b want %b", i, rx_q[i].bits, model_frame(exp_q[i]));
            end
            if (i > 0) begin
                checks++; if (rx_q[i].start_c - rx_q[i-1].end_c < GAP) begin
                    errors++; $display("FAIL b2b_gap%0d: got %0d want >= %0d", i, rx_q[i].start_c - rx_q[i-1].end_c, GAP);
                end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int hs;
        do_reset();
        send_event(8'h2B, 1'b0, 1'b0, hs);
        send_event(8'h33, 1'b0, 1'b0, hs);
        for (int i = 0; i < 300 && mon_nb != 6; i++) @(negedge CLOCK_50);
        checks++; if (mon_nb != 6 || ps2_clk !== 1'b0 || ps2_dat !== 1'b0) begin
            errors++; $display("FAIL mid_setup: got bit %0d clk %b dat %b want 6 0 0", mon_nb, ps2_clk, ps2_dat);
        end
        #1 resetn = 1'b0;
        #1;
        checks++; if (ps2_clk !== 1'b1) begin errors++; $display("FAIL mid_clk: got %b want 1", ps2_clk); end
        checks++; if (ps2_dat !== 1'b1) begin errors++; $display("FAIL mid_dat: got %b want 1", ps2_dat); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL mid_count: got %0d want 0", fifo_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b want 0", busy); end
        repeat (3) @(negedge CLOCK_50);
        resetn = 1'b1;
        rx_q.delete();
        @(negedge CLOCK_50);
        send_event(8'h4D, 1'b0, 1'b0, hs);
        wait_frames(1, 300);
        repeat (100) @(negedge CLOCK_50);
        checks++; if (rx_q.size() != 1) begin errors++; $display("FAIL mid_frames: got %0d want 1", rx_q.size()); end
        if (rx_q.size() >= 1) begin
            checks++; if (rx_q[0].bits !== model_frame(8'h4D)) begin errors++; $display("FAIL mid_bits: got %b want %b", rx_q[0].bits, model_frame(8'h4D)); end
            checks++; if (rx_q[0].start_c != hs + 3) begin errors++; $display("FAIL mid_latency: got %0d want 3", rx_q[0].start_c - hs); end
        end
    endtask

    task automatic test_random();
        int hs;
        logic [7:0] c;
        logic e, b;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            case ($urandom_range(0, 4))
                0: c = 8'hE0;
                1: c = 8'hF0;
                default: c = 8'($urandom_range(0, 255));
            endcase
            e = 1'($urandom_range(0, 1));
            b = 1'($urandom_range(0, 1));
            push_event(c, e, b);
            send_event(c, e, b, hs);
        end
        wait_frames(exp_q.size(), 6000);
        checks++; if (rx_q.size() < exp_q.size()) begin errors++; $display("FAIL rnd_frames: got %0d want %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            checks++; if (rx_q[i].bits !== model_frame(exp_q[i])) begin
                errors++; $display("FAIL rnd_byte%0d: got %b want %b", i, rx_q[i].bits, model_frame(exp_q[i]));
            end
        end
    endtask

`ifdef PS2_TYPEMATIC_EN
    task automatic test_typematic();
        int hs;
        do_reset();
        send_event(8'h1C, 1'b0, 1'b0, hs);
        wait_frames(3, 1500);
        checks++; if (rx_q.size() != 3) begin errors++; $display("FAIL tm_frames: got %0d want 3", rx_q.size()); end
        if (rx_q.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                checks++; if (rx_q[i].bits !== model_frame(8'h1C)) begin
                    errors++; $display("FAIL tm_byte%0d: got %b want %b", i, rx_q[i].bits, model_frame(8'h1C));
                end
            end
            checks++; if (rx_q[1].start_c - rx_q[0].end_c != 200) begin
                errors++; $display("FAIL tm_delay: got %0d want 200", rx_q[1].start_c - rx_q[0].end_c);
            end
            checks++; if (rx_q[2].start_c - rx_q[1].end_c != 100) begin
                errors++; $display("FAIL tm_period: got %0d want 100", rx_q[2].start_c - rx_q[1].end_c);
            end
            send_event(8'h1C, 1'b0, 1'b1, hs);
            wait_frames(5, 800);
            checks++; if (rx_q.size() != 5) begin errors++; $display("FAIL tm_break_frames: got %0d want 5", rx_q.size()); end
            if (rx_q.size() == 5) begin
                checks++; if (rx_q[3].bits !== model_frame(8'hF0) || rx_q[4].bits !== model_frame(8'h1C)) begin
                    errors++; $display("FAIL tm_break_bytes: got %b %b want %b %b", rx_q[3].bits, rx_q[4].bits,
                                       model_frame(8'hF0), model_frame(8'h1C));
                end
            end
            repeat (400) @(negedge CLOCK_50);
            checks++; if (rx_q.size() != 5) begin errors++; $display("FAIL tm_no_repeat: got %0d want 5", rx_q.size()); end
        end
    endtask
`else
    task automatic test_no_repeat();
        int hs;
        do_reset();
        send_event(8'h1C, 1'b0, 1'b0, hs);
        wait_frames(1, 400);
        repeat (500) @(negedge CLOCK_50);
        checks++; if (rx_q.size() != 1) begin errors++; $display("FAIL no_repeat: got %0d want 1", rx_q.size()); end
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn   = 1'b0;
        ev_valid = 1'b0;
        ev_code  = 8'h00;
        ev_ext   = 1'b0;
        ev_break = 1'b0;
        test_reset();
        test_single();
        test_ext_break();
        test_parity();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
`ifdef PS2_TYPEMATIC_EN
        test_typematic();
`else
        test_no_repeat();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
